// File: rtl/nand_adder.sv
// 1-bit full adder from nine 2-input NANDs with a registered copy of S/Cout.
// Optional NAND_ADDER_CHECK_EN adds a golden-model comparator with a sticky err flag.
module nand_adder #(
   parameter real GATE_DELAY = 0.0
) (
   input  logic clock,
   input  logic reset,
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic S,
   output logic Cout,
   output logic S_q,
   output logic Cout_q
`ifdef NAND_ADDER_CHECK_EN
   ,
   output logic err
`endif
);

   // Timing annotation is simulation-only; only its legal range is enforced here.
   if ((GATE_DELAY < 0.0) || (GATE_DELAY > 1.0)) begin : g_illegal_gate_delay
      $error("nand_adder: GATE_DELAY out of range 0..1");
   end

   wire w_n1, w_n2, w_n3, w_x;
   wire w_n4, w_n5, w_n6, w_s, w_cout;

   nand g_n1 (w_n1, A, B);
   nand g_n2 (w_n2, A, w_n1);
   nand g_n3 (w_n3, B, w_n1);
   nand g_x  (w_x, w_n2, w_n3);

   nand g_n4 (w_n4, w_x, Cin);
   nand g_n5 (w_n5, w_x, w_n4);
   nand g_n6 (w_n6, Cin, w_n4);
   nand g_s  (w_s, w_n5, w_n6);

   // n1 and n4 are the shared intermediates of both XOR stages, so carry costs one gate.
   nand g_co (w_cout, w_n1, w_n4);

   assign S    = w_s;
   assign Cout = w_cout;

   logic r_s_q;
   logic r_cout_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_s_q    <= 1'b0;
         r_cout_q <= 1'b0;
      end else begin
         r_s_q    <= w_s;
         r_cout_q <= w_cout;
      end
   end

   assign S_q    = r_s_q;
   assign Cout_q = r_cout_q;

`ifdef NAND_ADDER_CHECK_EN
   logic [1:0] w_gold;
   logic       r_err;

   assign w_gold = {1'b0, A} + {1'b0, B} + {1'b0, Cin};

   // The comparator only samples the netlist outputs; it adds a flop, not a path in the adder.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if ({w_cout, w_s} != w_gold) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`endif

endmodule

// File: tb/tb_nand_adder.sv
// Self-checking bench for nand_adder: comb truth table, toggle/random patterns,
// register latency and reset priority via scoreboard queues.
`timescale 1ns / 100ps
module tb_nand_adder;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic A = 1'b0, B = 1'b0, Cin = 1'b0;
   logic S, Cout, S_q, Cout_q;
`ifdef NAND_ADDER_CHECK_EN
   logic err;
`endif

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b1;
   logic [1:0] comb_q[$];
   logic [1:0] reg_q[$];
   logic [1:0] last_reg_exp = 2'b00;

   nand_adder dut (
      .clock (clock),
      .reset (reset),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .S     (S),
      .Cout  (Cout),
      .S_q   (S_q),
      .Cout_q(Cout_q)
`ifdef NAND_ADDER_CHECK_EN
      ,
      .err   (err)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Independent reference: {Cout,S}
   function automatic logic [1:0] model(input logic a, input logic b, input logic c);
      logic [1:0] r;
      r[0] = a ^ b ^ c;
      r[1] = (a & b) | (c & (a ^ b));
      return r;
   endfunction

   // Register scoreboard: expectation captured at each edge, checked half a cycle later.
   always @(posedge clock) begin
      if (mon_en) begin
         last_reg_exp = reset ? 2'b00 : model(A, B, Cin);
         reg_q.push_back(last_reg_exp);
      end
   end

   always @(negedge clock) begin
      if (mon_en && reg_q.size() > 0) begin
         check("reg", {Cout_q, S_q}, reg_q.pop_front());
      end
   end

   // Drive one input step at the falling edge and check comb outputs 1 ns later.
   task automatic step(input string tag, input logic a_v, input logic b_v, input logic c_v,
                       input logic [1:0] exp_v);
      @(negedge clock);
      A = a_v; B = b_v; Cin = c_v;
      comb_q.push_back(exp_v);
      #1;
      $display("%s: A=%b B=%b Cin=%b -> S=%b Cout=%b S_q=%b Cout_q=%b",
               tag, A, B, Cin, S, Cout, S_q, Cout_q);
      check(tag, {Cout, S}, comb_q.pop_front());
   endtask

   initial begin
      logic [7:0] s_tab, c_tab;
      logic [2:0] v;
      s_tab = 8'b1001_0110;
      c_tab = 8'b1110_1000;

      // Reset held for two edges.
      @(posedge clock);
      @(posedge clock);
      #1;
      check("rst_q", {Cout_q, S_q}, 2'b00);

      // Exhaustive truth table against literal table, index = {Cin,B,A}.
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         step("tt", v[0], v[1], v[2], {c_tab[i], s_tab[i]});
      end

      // Release reset, 111 -> registers follow after next edge.
      @(negedge clock);
      reset = 1'b0;
      step("lat_111", 1'b1, 1'b1, 1'b1, 2'b11);
      @(posedge clock);
      #1;
      check("lat_q111", {Cout_q, S_q}, 2'b11);
      step("lat_000", 1'b0, 1'b0, 1'b0, 2'b00);
      check("lat_hold", {Cout_q, S_q}, 2'b11);
      @(posedge clock);
      #1;
      check("lat_q000", {Cout_q, S_q}, 2'b00);

      // Toggle pattern: A/10ns, B/20ns, Cin/40ns over 80 ns.
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         step("tog", v[0], v[1], v[2], model(v[0], v[1], v[2]));
      end

      // Reset priority over capture; comb path unaffected.
      @(negedge clock);
      reset = 1'b1;
      step("rp_100", 1'b1, 1'b0, 1'b0, 2'b01);
      @(posedge clock);
      #1;
      check("rp_q0", {Cout_q, S_q}, 2'b00);
      check("rp_s1", {Cout, S}, 2'b01);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("rp_q1", {Cout_q, S_q}, 2'b01);

      // Simultaneous change of all three inputs.
      step("sim_011", 1'b0, 1'b1, 1'b1, 2'b10);
      step("sim_100", 1'b1, 1'b0, 1'b0, 2'b01);

      // Random patterns.
      for (int i = 0; i < 16; i++) begin
         v = 3'($urandom_range(0, 7));
         step("rnd", v[0], v[1], v[2], model(v[0], v[1], v[2]));
      end

`ifdef NAND_ADDER_CHECK_EN
      // Clean run: every combination sees one edge, err stays low.
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         step("chk_tt", v[0], v[1], v[2], model(v[0], v[1], v[2]));
      end
      @(negedge clock);
      check("err_clean", {1'b0, err}, 2'b00);

      // Stuck-at-1 on n1 must be flagged for input 110.
      mon_en = 1'b0;
      @(negedge clock);
      reg_q.delete();
      A = 1'b1; B = 1'b1; Cin = 1'b0;
      force dut.w_n1 = 1'b1;
      @(negedge clock);
      check("err_set", {1'b0, err}, 2'b01);
      release dut.w_n1;
      reset = 1'b1;
      @(negedge clock);
      check("err_clr", {1'b0, err}, 2'b00);
      reset = 1'b0;
`endif

      @(negedge clock);
      @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
